// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multicycle main control FSM: state codes, instruction
// fields and the datapath select codes used by the datapath and the bench.
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StJr       = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] PcAluRes = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcRegA   = 2'b11;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface main_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       read_sel;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state;

  modport master (
    input  opcode, funct,
    output read_sel, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state
  );

  modport slave (
    output opcode, funct,
    input  read_sel, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS-style main control: state register, next-state logic and
// Moore output decode (plus the DECODE-time read-port select for jr).
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input logic                clk,
  input logic                rst,
  main_control_fsm_if.master bus
);

  state_e state_q;
  logic   is_lw_q;

  // Load/store kind is captured in DECODE so MEMADR ignores later opcode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      is_lw_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          is_lw_q <= (bus.opcode == OpLw);
          case (bus.opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= (bus.funct == FnJr) ? StJr : StExecute;
            OpBeq:      state_q <= StBranch;
            OpAddi:     state_q <= StAddiEx;
            OpJ:        state_q <= StJump;
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr:  state_q <= is_lw_q ? StMemRead : StMemWrite;
        StMemRead: state_q <= StMemWb;
        StExecute: state_q <= StAluWb;
        StAddiEx:  state_q <= StAddiWb;
        default:   state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    bus.read_sel      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SrcBReg;
    bus.alu_op        = AluAdd;
    bus.pc_src        = PcAluRes;
    bus.state         = state_q;
    case (state_q)
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = 1'b1;
        bus.alu_src_b = SrcBFour;
        bus.pc_write  = 1'b1;
      end
      StDecode: begin
        bus.alu_src_b = SrcBImmSh2;
        bus.read_sel  = (bus.opcode == OpRtype) && (bus.funct == FnJr);
      end
      StMemAdr, StAddiEx: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SrcBImm;
      end
      StMemRead: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      StExecute: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = AluFunct;
      end
      StAluWb: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = AluSub;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PcAluOut;
      end
      StAddiWb: bus.reg_write = 1'b1;
      StJump: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PcJump;
      end
      StJr: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PcRegA;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: walks each instruction class and reset cases.
module tb_main_control_fsm;
  import main_control_fsm_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input string tag, input logic [3:0] exp_state);
    @(negedge clk);
    chk(tag, bus.state, exp_state);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    bus.opcode = OpLw;
    bus.funct  = 6'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", bus.state, 4'd0);
    chk("rst_memread", {3'b0, bus.mem_read}, 4'd1);
    chk("rst_pcwrite", {3'b0, bus.pc_write}, 4'd1);
    chk("rst_memwrite", {3'b0, bus.mem_write}, 4'd0);
    chk("rst_regwrite", {3'b0, bus.reg_write}, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // lw: 0,1,2,3,4,0
    @(negedge clk);
    chk("lw_s0", bus.state, 4'd0);
    chk("lw_irwrite", {3'b0, bus.ir_write}, 4'd1);
    chk("lw_srcb_fetch", {2'b0, bus.alu_src_b}, {2'b0, SrcBFour});
    nxt("lw_s1", 4'd1);
    chk("lw_srcb_dec", {2'b0, bus.alu_src_b}, {2'b0, SrcBImmSh2});
    chk("lw_readsel_dec", {3'b0, bus.read_sel}, 4'd0);
    nxt("lw_s2", 4'd2);
    chk("lw_srca_adr", {3'b0, bus.alu_src_a}, 4'd1);
    chk("lw_srcb_adr", {2'b0, bus.alu_src_b}, {2'b0, SrcBImm});
    nxt("lw_s3", 4'd3);
    chk("lw_iord", {3'b0, bus.i_or_d}, 4'd1);
    chk("lw_regwrite_s3", {3'b0, bus.reg_write}, 4'd0);
    nxt("lw_s4", 4'd4);
    chk("lw_regwrite_s4", {3'b0, bus.reg_write}, 4'd1);
    chk("lw_memtoreg_s4", {3'b0, bus.mem_to_reg}, 4'd1);
    nxt("lw_s0_end", 4'd0);
    chk("lw_memtoreg_end", {3'b0, bus.mem_to_reg}, 4'd0);

    // sw with opcode changed to lw during MEMADR: still 2 -> 5
    bus.opcode = OpSw;
    nxt("sw_s1", 4'd1);
    nxt("sw_s2", 4'd2);
    bus.opcode = OpLw;
    nxt("sw_s5", 4'd5);
    chk("sw_memwrite", {3'b0, bus.mem_write}, 4'd1);
    chk("sw_iord", {3'b0, bus.i_or_d}, 4'd1);
    nxt("sw_s0", 4'd0);

    // R-type add
    bus.opcode = OpRtype;
    bus.funct  = 6'b100000;
    nxt("r_s1", 4'd1);
    chk("r_readsel", {3'b0, bus.read_sel}, 4'd0);
    nxt("r_s6", 4'd6);
    chk("r_aluop", {2'b0, bus.alu_op}, {2'b0, AluFunct});
    chk("r_srcb", {2'b0, bus.alu_src_b}, {2'b0, SrcBReg});
    nxt("r_s7", 4'd7);
    chk("r_regdst", {3'b0, bus.reg_dst}, 4'd1);
    chk("r_regwrite", {3'b0, bus.reg_write}, 4'd1);
    nxt("r_s0", 4'd0);

    // jr
    bus.funct = FnJr;
    chk("jr_readsel_fetch", {3'b0, bus.read_sel}, 4'd0);
    nxt("jr_s1", 4'd1);
    chk("jr_readsel_dec", {3'b0, bus.read_sel}, 4'd1);
    nxt("jr_s12", 4'd12);
    chk("jr_pcsrc", {2'b0, bus.pc_src}, {2'b0, PcRegA});
    chk("jr_pcwrite", {3'b0, bus.pc_write}, 4'd1);
    chk("jr_readsel_s12", {3'b0, bus.read_sel}, 4'd0);
    nxt("jr_s0", 4'd0);

    // beq
    bus.opcode = OpBeq;
    bus.funct  = 6'd0;
    nxt("beq_s1", 4'd1);
    nxt("beq_s8", 4'd8);
    chk("beq_pwc", {3'b0, bus.pc_write_cond}, 4'd1);
    chk("beq_aluop", {2'b0, bus.alu_op}, {2'b0, AluSub});
    chk("beq_pcwrite", {3'b0, bus.pc_write}, 4'd0);
    chk("beq_pcsrc", {2'b0, bus.pc_src}, {2'b0, PcAluOut});
    nxt("beq_s0", 4'd0);

    // addi
    bus.opcode = OpAddi;
    nxt("addi_s1", 4'd1);
    nxt("addi_s9", 4'd9);
    chk("addi_srcb", {2'b0, bus.alu_src_b}, {2'b0, SrcBImm});
    nxt("addi_s10", 4'd10);
    chk("addi_regwrite", {3'b0, bus.reg_write}, 4'd1);
    chk("addi_regdst", {3'b0, bus.reg_dst}, 4'd0);
    nxt("addi_s0", 4'd0);

    // j
    bus.opcode = OpJ;
    nxt("j_s1", 4'd1);
    nxt("j_s11", 4'd11);
    chk("j_pcsrc", {2'b0, bus.pc_src}, {2'b0, PcJump});
    chk("j_pcwrite", {3'b0, bus.pc_write}, 4'd1);
    nxt("j_s0", 4'd0);

    // unknown opcode
    bus.opcode = 6'b111111;
    nxt("unk_s1", 4'd1);
    chk("unk_regwrite", {3'b0, bus.reg_write}, 4'd0);
    chk("unk_memwrite", {3'b0, bus.mem_write}, 4'd0);
    nxt("unk_s0", 4'd0);
    chk("unk_regwrite_end", {3'b0, bus.reg_write}, 4'd0);

    // reset mid-MEMREAD
    bus.opcode = OpLw;
    nxt("rmr_s1", 4'd1);
    nxt("rmr_s2", 4'd2);
    nxt("rmr_s3", 4'd3);
    rst = 1'b1;
    #1;
    chk("rmr_async_state", bus.state, 4'd0);
    chk("rmr_memwrite", {3'b0, bus.mem_write}, 4'd0);
    chk("rmr_regwrite", {3'b0, bus.reg_write}, 4'd0);
    nxt("rmr_hold", 4'd0);
    chk("rmr_hold_regwrite", {3'b0, bus.reg_write}, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    nxt("rmr_rel0", 4'd0);
    nxt("rmr_rel1", 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset; forces state to FETCH immediately.
REQ-003 Opcode  input  6  Instr[31:26] from instruction register; sampled only in DECODE.
REQ-004 Funct  input  6  Instr[5:0]; sampled only in DECODE.
REQ-005 ReadSel  output  1  drives read-port-1 address mux select; 0 = Instr[25:21], 1 = Instr[15:11].
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-007 ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
REQ-008 ALUOp  output  2  00 = add, 01 = sub, 10 = decode by Funct.
REQ-009 PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
REQ-010 State  output  4  current state code, for debug/verification.

Function
REQ-011 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JR=12.
REQ-012 FETCH -> DECODE unconditionally; outputs MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1.
REQ-013 DECODE outputs ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by Opcode: 100011/101011 -> MEMADR, 000000 & Funct=001000 -> JR, other 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH.
REQ-014 ReadSel=1 only when State=DECODE, Opcode=000000 and Funct=001000 (JR target taken from rd field); 0 in every other case.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMREAD if Opcode=100011, else MEMWRITE.
REQ-016 MEMREAD: MemRead=1, IorD=1 -> MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
REQ-017 MEMWRITE: MemWrite=1, IorD=1 -> FETCH.
REQ-018 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01 -> FETCH.
REQ-020 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
REQ-021 JUMP: PCWrite=1, PCSrc=10 -> FETCH. JR: PCWrite=1, PCSrc=11 -> FETCH.
REQ-022 Any signal not listed for a state is 0; outputs are combinational from State (plus REQ-014 term); no glitch-sensitive use outside Clk domain.
REQ-023 Cycles per instruction including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jr 3, unknown opcode 2.
REQ-024 Unused encodings 13-15 -> FETCH next cycle with all strobes 0.
REQ-025 Opcode/Funct changes outside DECODE have no effect on state sequence.

Reset
REQ-026 Reset asserted at any time, including mid-instruction: State=FETCH asynchronously, no pending write strobe survives.
REQ-027 While Reset=1, State holds FETCH and outputs show FETCH decode but PC/IR updates are the datapath's concern; first full FETCH occurs on first rising Clk after Reset deasserts.

Structure
REQ-028 State encodings, opcode/funct constants and ALUSrcB/ALUOp/PCSrc codes live in a shared package used by datapath and bench.
REQ-029 Single module: state register + next-state logic + output decode; no sub-module.

Verification
REQ-030 Reset mid-MEMREAD, release -> State=0 immediately, then 0,1 on next two edges, MemWrite/RegWrite never 1 during reset.
REQ-031 Opcode=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-032 Opcode=000000, Funct=001000 -> ReadSel=1 only in DECODE; sequence 0,1,12,0; PCSrc=11, PCWrite=1 in state 12.
REQ-033 Opcode=000100 -> 0,1,8,0; PCWriteCond=1, ALUOp=01, PCWrite=0 in state 8.
REQ-034 Opcode=111111 -> 0,1,0; no RegWrite/MemWrite asserted; Opcode toggled during MEMADR of sw (101011) -> still 2,5.
